// File: rtl/add_sub_4bit_unit.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_4bit_unit
// Purpose  : Registered 4-bit two's-complement adder/subtractor used as a
//            small ALU slice. Computes a+b (op=0) or a-b (op=1) through a
//            ripple-carry chain and registers the result, carry-out and
//            signed-overflow flag one clock after the operands are captured.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous, active-high reset
//            a, b      - 4-bit operands
//            op        - 0 = add, 1 = subtract (a - b)
//            in_valid  - operands valid, capture this cycle
//            sum       - registered result bits [3:0]
//            Cout      - registered carry out of bit 3
//            v         - registered signed-overflow flag
//            out_valid - one-cycle pulse per new result
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_4bit_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       op,
  input  logic       in_valid,
  output logic [3:0] sum,
  output logic       Cout,
  output logic       v,
  output logic       out_valid
);

  localparam int c_WIDTH = 4;

  logic [c_WIDTH-1:0] w_bx;   // b conditionally inverted for subtraction
  logic [c_WIDTH:0]   w_c;    // ripple carries, w_c[0] is the carry-in
  logic [c_WIDTH-1:0] w_s;    // combinational sum bits
  logic               w_v;    // signed overflow of the current operands

  logic [c_WIDTH-1:0] r_sum;
  logic               r_cout;
  logic               r_v;
  logic               r_out_valid;

  // Subtraction is a + ~b + 1: invert b and feed op in as the carry-in.
  assign w_bx   = b ^ {c_WIDTH{op}};
  assign w_c[0] = op;

  generate
    for (genvar i = 0; i < c_WIDTH; i++) begin : g_fa
      assign w_s[i]   = a[i] ^ w_bx[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & w_bx[i]) | (a[i] & w_c[i]) | (w_bx[i] & w_c[i]);
    end
  endgenerate

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign w_v = w_c[c_WIDTH-1] ^ w_c[c_WIDTH];

  // Result registers only load on a valid beat; otherwise they hold so the
  // last result stays observable while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[c_WIDTH];
        r_v    <= w_v;
      end
    end
  end

  assign sum       = r_sum;
  assign Cout      = r_cout;
  assign v         = r_v;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_4bit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sub_4bit_unit
// Purpose  : Self-checking bench for add_sub_4bit_unit. Expected results are
//            queued when operands are driven and compared when out_valid
//            rises; idle cycles check that the last result is held.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_4bit_unit;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [3:0] sum;
    logic       cout;
    logic       v;
  } vec_t;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       v;
  } res_t;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       op;
  logic       in_valid;
  logic [3:0] sum;
  logic       Cout;
  logic       v;
  logic       out_valid;

  int   n_cmp;
  int   n_bad;
  res_t sb_q[$];
  res_t last_exp;
  vec_t tbl[12];

  add_sub_4bit_unit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .sum       (sum),
    .Cout      (Cout),
    .v         (v),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model built from integer arithmetic, not from the carry chain.
  function automatic res_t model(input logic [3:0] ia, input logic [3:0] ib, input logic iop);
    res_t r;
    int   sa, sb, sr, ua, ub;
    ua = int'(ia);
    ub = int'(ib);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    sr = iop ? sa - sb : sa + sb;
    r.sum  = iop ? 4'(ua - ub) : 4'(ua + ub);
    r.cout = iop ? (ua >= ub) : (ua + ub > 15);
    r.v    = (sr < -8) || (sr > 7);
    return r;
  endfunction

  // Drive one beat at the falling edge; queue its expected result if valid.
  task automatic drive(input logic [3:0] ia, input logic [3:0] ib, input logic iop,
                       input logic vld, input res_t exp);
    @(negedge clk);
    a        = ia;
    b        = ib;
    op       = iop;
    in_valid = vld;
    if (vld && !rst) sb_q.push_back(exp);
  endtask

  // Monitor: one sample per rising edge, 1 time unit after the edge.
  always @(posedge clk) begin
    logic exp_ov;
    res_t e;
    exp_ov = in_valid && !rst;
    #1;
    check("out_valid", {3'b0, out_valid}, {3'b0, exp_ov});
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got out_valid=1 expected no pending result");
      end else begin
        e = sb_q.pop_front();
        check("sum",  sum,           e.sum);
        check("Cout", {3'b0, Cout},  {3'b0, e.cout});
        check("v",    {3'b0, v},     {3'b0, e.v});
        last_exp = e;
      end
    end else begin
      check("hold_sum",  sum,          last_exp.sum);
      check("hold_Cout", {3'b0, Cout}, {3'b0, last_exp.cout});
      check("hold_v",    {3'b0, v},    {3'b0, last_exp.v});
    end
  end

  initial begin
    res_t m;
    n_cmp    = 0;
    n_bad    = 0;
    last_exp = '{sum: 4'h0, cout: 1'b0, v: 1'b0};

    //             a      b      op    sum    cout  v
    tbl[0]  = '{4'd1,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0};
    tbl[1]  = '{4'd7,  4'd7,  1'b0, 4'd14, 1'b0, 1'b1};
    tbl[2]  = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0, 1'b0};
    tbl[3]  = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    tbl[4]  = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
    tbl[5]  = '{4'd15, 4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
    tbl[6]  = '{4'd13, 4'd2,  1'b1, 4'd11, 1'b1, 1'b0};
    tbl[7]  = '{4'd12, 4'd5,  1'b1, 4'd7,  1'b1, 1'b1};
    tbl[8]  = '{4'd10, 4'd7,  1'b1, 4'd3,  1'b1, 1'b1};
    tbl[9]  = '{4'd8,  4'd8,  1'b1, 4'd0,  1'b1, 1'b0};
    tbl[10] = '{4'd8,  4'd9,  1'b1, 4'd15, 1'b0, 1'b0};
    tbl[11] = '{4'd5,  4'd3,  1'b1, 4'd2,  1'b1, 1'b0};

    rst      = 1'b1;
    a        = 4'h0;
    b        = 4'h0;
    op       = 1'b0;
    in_valid = 1'b0;
    #2;
    check("reset_sum",       sum,               4'h0);
    check("reset_Cout",      {3'b0, Cout},      4'h0);
    check("reset_v",         {3'b0, v},         4'h0);
    check("reset_out_valid", {3'b0, out_valid}, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, spaced with idle beats so hold is checked between them.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].op, 1'b1,
            '{sum: tbl[i].sum, cout: tbl[i].cout, v: tbl[i].v});
      drive(4'(i), 4'(~i), ~tbl[i].op, 1'b0, m);
    end

    // Throughput: the same 12 plus 10 random vectors, back to back.
    for (int i = 0; i < 12; i++)
      drive(tbl[i].a, tbl[i].b, tbl[i].op, 1'b1,
            '{sum: tbl[i].sum, cout: tbl[i].cout, v: tbl[i].v});
    for (int i = 0; i < 10; i++) begin
      logic [3:0] ra, rb;
      logic       rop;
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 1'($urandom_range(0, 1));
      drive(ra, rb, rop, 1'b1, model(ra, rb, rop));
    end

    // Hold: three idle beats with changing operands.
    drive(4'd3, 4'd9,  1'b0, 1'b0, m);
    drive(4'd15, 4'd1, 1'b1, 1'b0, m);
    drive(4'd6, 4'd12, 1'b0, 1'b0, m);

    // Reset mid-cycle right after a nonzero result.
    drive(4'd7, 4'd7, 1'b0, 1'b1, model(4'd7, 4'd7, 1'b0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb_q.delete();
    last_exp = '{sum: 4'h0, cout: 1'b0, v: 1'b0};
    #1;
    check("async_rst_sum",       sum,               4'h0);
    check("async_rst_Cout",      {3'b0, Cout},      4'h0);
    check("async_rst_v",         {3'b0, v},         4'h0);
    check("async_rst_out_valid", {3'b0, out_valid}, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // Exhaustive sweep of all operand/op combinations.
    for (int o = 0; o < 2; o++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          drive(4'(ia), 4'(ib), 1'(o), 1'b1, model(4'(ia), 4'(ib), 1'(o)));

    drive(4'h0, 4'h0, 1'b0, 1'b0, m);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 4'(sb_q.size()), 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_sub_4bit_unit.md
Name: add_sub_4bit_unit

Overview:
Registered 4-bit two's-complement adder/subtractor with carry-out and signed-overflow flags. Computes a+b when op=0 and a−b when op=1. Uses a ripple-carry chain: b is XORed with op, and op is also the carry-in. Results are captured in output registers, so they appear one clock after the inputs. Used as a small ALU slice in the datapath.

Parameters:
None. Width is fixed at 4 bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
a  input  4  operand A
b  input  4  operand B
op  input  1  0 = add, 1 = subtract (a − b)
in_valid  input  1  operands valid; capture this cycle
sum  output  4  registered result, bits [3:0]
Cout  output  1  registered carry out of bit 3
v  output  1  registered signed-overflow flag
out_valid  output  1  registered; high for one cycle when sum/Cout/v hold a new result

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, sum=4'h0, Cout=0, v=0 and out_valid=0, with no wait for a clock edge. Deassertion is sampled on clk.
- Reset mid-operation: any result in flight is discarded. out_valid is not asserted for operands captured in the cycle rst was high.
- Datapath (combinational):
  - bx[i] = b[i] XOR op.
  - c0 = op.
  - Four full adders: s[i] = a[i] ^ bx[i] ^ c[i]; c[i+1] = majority(a[i], bx[i], c[i]).
  - Cout_next = c4.
  - v_next = c3 XOR c4.
- Register update: on a rising clk edge with rst=0 and in_valid=1, load sum<=s, Cout<=c4, v<=c3^c4, out_valid<=1.
- Hold: on a rising edge with in_valid=0, out_valid<=0 and sum/Cout/v keep their previous values.
- Latency: exactly 1 cycle, full throughput. Back-to-back in_valid gives out_valid high continuously.
- No backpressure: out_valid is not held waiting for a consumer.
- Flag semantics:
  - Add: Cout=1 means unsigned overflow (a+b > 15).
  - Subtract: Cout=1 means no borrow (unsigned a >= b); Cout=0 means borrow.
  - v=1 means the signed result lies outside −8..+7.
- Wrap-around: sum is always the true result modulo 16.
- Subtract with b=0: the operation is a + 4'hF + 1, so Cout=1 and v=0.
- op, a and b are only sampled when in_valid=1.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with a prior nonzero result. Outputs go to 0 immediately, and out_valid=0 after rst is released with in_valid=0.
- Addition sweep, op=0, in_valid=1, each checked one cycle later:
  - 1+3 → sum=4, Cout=0, v=0
  - 7+7 → sum=14, Cout=0, v=1
  - 7+8 → sum=15, Cout=0, v=0
  - 8+8 → sum=0, Cout=1, v=1
  - 0+0 → sum=0, Cout=0, v=0
- Subtraction sweep, op=1:
  - 15−0 → sum=15, Cout=1, v=0
  - 13−2 → sum=11, Cout=1, v=0
  - 12−5 → sum=7, Cout=1, v=1
  - 10−7 → sum=3, Cout=1, v=1
  - 8−8 → sum=0, Cout=1, v=0
  - 8−9 → sum=15, Cout=0, v=0
  - 5−3 → sum=2, Cout=1, v=0
- Throughput: apply the 22-vector sequence on consecutive cycles with in_valid=1. Results appear in order one cycle later, and out_valid stays high throughout.
- Hold: drop in_valid for 3 cycles while changing a, b and op. sum, Cout and v stay unchanged and out_valid=0.
- Exhaustive: all 512 combinations of a, b and op are checked against a reference model of sum, Cout and v.
